// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared USART types and constants
//
// Purpose: receive-FSM state encoding and frame constants shared by the
//          USART receive and transmit stages.
// Ports:   none (package).
package usart_pkg;

  localparam int USART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } usart_rx_state_t;

endpackage

// File: rtl/usart_sync.sv
// rtl/usart_sync.sv - two-flop synchronizer for an asynchronous input
//
// Purpose: brings an asynchronous single-bit signal into the i_clock domain.
// Ports:
//   i_clock  in  system clock, rising edge
//   i_reset  in  synchronous active-high reset; both flops load RESET_VAL
//   i_async  in  asynchronous input
//   o_sync   out synchronized output, two cycles of latency
module usart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/usart_rx.sv
// rtl/usart_rx.sv - oversampling 8N1 serial receiver with one-entry output register
//
// Purpose: recovers idle-high 8N1 frames (start 0, 8 data bits LSB first,
//          stop 1) from rx_pin and holds each byte in a valid/ready register.
// Ports:
//   clock          in  system clock, rising edge
//   reset          in  synchronous active-high reset
//   rx_pin         in  asynchronous serial line, idle high
//   rx_data        out received byte, valid while rx_valid
//   rx_valid       out holding register full
//   rx_ready       in  consumer accepts when rx_valid && rx_ready
//   framing_error  out one-cycle pulse, stop bit sampled low
//   overrun        out one-cycle pulse, completed byte dropped (register full)
module usart_rx
  import usart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 104
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx_pin,
  output logic [USART_DATA_BITS-1:0] rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       framing_error,
  output logic                       overrun
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(USART_DATA_BITS);

  localparam logic [CW-1:0] CNT_FULL = CW'(CLOCKS_PER_BIT - 1);
  // First sample lands mid start bit, so every later sample is mid-bit too.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(USART_DATA_BITS - 1);

  usart_rx_state_t r_state;
  usart_rx_state_t w_state_next;

  logic [CW-1:0]              r_cnt;
  logic [IW-1:0]              r_idx;
  logic [USART_DATA_BITS-1:0] r_shift;
  logic [USART_DATA_BITS-1:0] r_data;
  logic                       r_valid;
  logic                       r_fe;
  logic                       r_ovr;

  logic                       w_rx_s;
  logic                       w_sample;
  logic [CW-1:0]              w_cnt_next;
  logic [IW-1:0]              w_idx_next;
  logic [USART_DATA_BITS-1:0] w_shift_next;
  logic                       w_load;
  logic                       w_drop;
  logic                       w_fe;

  usart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_async (rx_pin),
    .o_sync  (w_rx_s)
  );

  assign w_sample = (r_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = w_sample ? r_cnt : r_cnt - CW'(1);
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_fe         = 1'b0;

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_next = START;
          w_cnt_next   = CNT_HALF;
        end
      end

      START: begin
        if (w_sample) begin
          if (!w_rx_s) begin
            w_state_next = DATA;
            w_cnt_next   = CNT_FULL;
            w_idx_next   = '0;
          end else begin
            // Line went back high before mid start bit: a glitch, ignored silently.
            w_state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (w_sample) begin
          w_shift_next = {w_rx_s, r_shift[USART_DATA_BITS-1:1]};
          w_cnt_next   = CNT_FULL;
          w_idx_next   = r_idx + IW'(1);
          if (r_idx == IDX_LAST) begin
            w_state_next = STOP;
          end
        end
      end

      STOP: begin
        if (w_sample) begin
          if (w_rx_s) begin
            // A same-cycle drain frees the register for the new byte.
            if (!r_valid || rx_ready) begin
              w_load = 1'b1;
            end else begin
              w_drop = 1'b1;
            end
            w_state_next = IDLE;
          end else begin
            w_fe         = 1'b1;
            w_state_next = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        // Hold off until the line is released so a break is one error, not many.
        if (w_rx_s) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_fe    <= w_fe;
      r_ovr   <= w_drop;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data       = r_data;
  assign rx_valid      = r_valid;
  assign framing_error = r_fe;
  assign overrun       = r_ovr;

endmodule

// File: tb/tb_usart_rx.sv
// tb/tb_usart_rx.sv - self-checking bench for usart_rx
module tb_usart_rx;

  localparam int N   = 16;
  localparam int LAT = 2 + N / 2 + 9 * N + 1;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       rx_pin   = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       framing_error;
  logic       overrun;

  usart_rx #(
    .CLOCKS_PER_BIT (N)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_pin        (rx_pin),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         xfer_cnt  = 0;
  int         rise_cnt  = 0;
  int         hi_cnt    = 0;
  int         fe_cnt    = 0;
  int         ovr_cnt   = 0;
  int         both_cnt  = 0;
  int         rise_cyc  = 0;
  logic [7:0] last_xfer = 8'h00;
  logic       prev_valid = 1'b0;

  always @(negedge clock) begin
    if (rx_valid && rx_ready) begin
      xfer_cnt  = xfer_cnt + 1;
      last_xfer = rx_data;
    end
    if (rx_valid && !prev_valid) begin
      rise_cnt = rise_cnt + 1;
      rise_cyc = cyc;
    end
    if (rx_valid) hi_cnt = hi_cnt + 1;
    if (framing_error) fe_cnt = fe_cnt + 1;
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (framing_error && overrun) both_cnt = both_cnt + 1;
    prev_valid = rx_valid;
  end

  int vecs = 0;
  int errs = 0;
  int fall_cyc = 0;
  int b_x, b_r, b_h, b_f, b_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    tick(n);
  endtask

  task automatic snap();
    b_x = xfer_cnt;
    b_r = rise_cnt;
    b_h = hi_cnt;
    b_f = fe_cnt;
    b_o = ovr_cnt;
  endtask

  // Leaves the line at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic stopb);
    fall_cyc = cyc;
    rx_pin   = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      tick(N);
    end
    rx_pin = stopb;
    tick(N);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    int         exp_xfer;
    int         exp_fe;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1, 0};
    tbl[3] = '{8'h3C, 1'b1, 1, 0};
    tbl[4] = '{8'h81, 1'b1, 1, 0};
    tbl[5] = '{8'h96, 1'b0, 0, 1};

    // Reset state
    reset = 1'b1; rx_pin = 1'b1; rx_ready = 1'b1;
    tick(3);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_fe", framing_error, 0);
    check("reset_ovr", overrun, 0);
    reset = 1'b0;
    idle(4);

    // Single frames, consumer always ready
    for (int i = 0; i < 6; i++) begin
      snap();
      send_frame(tbl[i].data, tbl[i].stopb);
      idle(6);
      check($sformatf("tbl%0d_xfer", i), xfer_cnt - b_x, tbl[i].exp_xfer);
      check($sformatf("tbl%0d_fe", i), fe_cnt - b_f, tbl[i].exp_fe);
      check($sformatf("tbl%0d_ovr", i), ovr_cnt - b_o, 0);
      check($sformatf("tbl%0d_valid_width", i), hi_cnt - b_h, tbl[i].exp_xfer);
      if (tbl[i].exp_xfer != 0) begin
        check($sformatf("tbl%0d_data", i), last_xfer, tbl[i].data);
        check($sformatf("tbl%0d_latency", i), rise_cyc - fall_cyc, LAT);
      end
    end

    // Overrun: two frames back-to-back with consumer stalled
    rx_ready = 1'b0;
    snap();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    check("ovr_count", ovr_cnt - b_o, 1);
    check("ovr_fe", fe_cnt - b_f, 0);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h00);
    check("ovr_no_xfer", xfer_cnt - b_x, 0);
    rx_ready = 1'b1;
    idle(3);
    check("ovr_drain_count", xfer_cnt - b_x, 1);
    check("ovr_drain_data", last_xfer, 8'h00);
    check("ovr_drain_valid", rx_valid, 0);

    // Framing error followed by a long break
    snap();
    send_frame(8'h96, 1'b0);
    tick(40 * N);
    check("brk_fe", fe_cnt - b_f, 1);
    check("brk_no_valid", rise_cnt - b_r, 0);
    check("brk_ovr", ovr_cnt - b_o, 0);
    idle(2 * N);
    check("brk_fe_after_rise", fe_cnt - b_f, 1);
    snap();
    send_frame(8'h3C, 1'b1);
    idle(6);
    check("brk_next_xfer", xfer_cnt - b_x, 1);
    check("brk_next_data", last_xfer, 8'h3C);

    // Short low glitch on an idle line
    snap();
    rx_pin = 1'b0;
    tick(5);
    idle(3 * N);
    check("glitch_fe", fe_cnt - b_f, 0);
    check("glitch_ovr", ovr_cnt - b_o, 0);
    check("glitch_valid", rise_cnt - b_r, 0);
    snap();
    send_frame(8'h81, 1'b1);
    idle(6);
    check("glitch_next_xfer", xfer_cnt - b_x, 1);
    check("glitch_next_data", last_xfer, 8'h81);

    // Reset in the middle of a frame, with a byte already held
    rx_ready = 1'b0;
    send_frame(8'h77, 1'b1);
    idle(4);
    check("rst_pre_valid", rx_valid, 1);
    check("rst_pre_data", rx_data, 8'h77);
    rx_pin = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rx_pin = (8'h55 >> i) & 1;
      tick(N);
    end
    rx_pin = 1'b1;
    reset  = 1'b1;
    tick(1);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_fe", framing_error, 0);
    check("rst_ovr", overrun, 0);
    snap();
    tick(N - 1);
    for (int i = 5; i < 8; i++) begin
      rx_pin = (8'h55 >> i) & 1;
      tick(N);
    end
    rx_pin = 1'b1;
    tick(N);
    reset = 1'b0;
    idle(4);
    check("rst_rest_no_valid", rise_cnt - b_r, 0);
    rx_ready = 1'b1;
    snap();
    send_frame(8'hC3, 1'b1);
    idle(6);
    check("rst_next_xfer", xfer_cnt - b_x, 1);
    check("rst_next_data", last_xfer, 8'hC3);

    // Drain and load on the same stop-sample cycle
    rx_ready = 1'b0;
    send_frame(8'h34, 1'b1);
    idle(4);
    snap();
    fork
      send_frame(8'h12, 1'b1);
      begin
        tick(LAT - 1);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end
    join
    idle(4);
    check("same_xfer", xfer_cnt - b_x, 1);
    check("same_old_data", last_xfer, 8'h34);
    check("same_ovr", ovr_cnt - b_o, 0);
    check("same_valid", rx_valid, 1);
    check("same_new_data", rx_data, 8'h12);
    check("same_valid_no_gap", rise_cnt - b_r, 0);

    check("fe_ovr_exclusive", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/usart_rx.md
# usart_rx

Serial receiver for the USART library. It recovers 8N1 frames from the asynchronous `rx_pin` line by oversampling on the system clock and presents each received byte on a one-entry valid/ready output register. It is the receiving counterpart of the transmit stage and consumes exactly the line format that stage produces: idle high, one start bit (0), 8 data bits LSB first, one stop bit (1). Framing and overrun conditions are reported as single-cycle pulses.

## Interface
- `CLOCKS_PER_BIT`, 104, system clocks per serial bit; legal range ≥ 4; half-bit = `CLOCKS_PER_BIT/2` (integer division).
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_pin`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  8  received byte; valid while `rx_valid`.
- `rx_valid`  out  1  holding register full.
- `rx_ready`  in  1  consumer accepts; transfer occurs on any cycle with `rx_valid && rx_ready`.
- `framing_error`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: completed byte dropped because the holding register was full.

## Operation
- Two-flop synchronizer on `rx_pin`, both flops reset to 1. The FSM sees only the synchronized signal `rx_s`.
- Bit counter: width `$clog2(CLOCKS_PER_BIT)`. It is loaded on state entry and decrements each cycle; the line is sampled on the cycle the counter equals 0.
- IDLE:
  - `rx_s == 0` → START, counter = half-bit − 1.
- START, on sample:
  - `rx_s == 0` → DATA, counter = `CLOCKS_PER_BIT − 1`, bit index = 0.
  - `rx_s == 1` → IDLE. This is a glitch: nothing is reported.
- DATA, on sample:
  - Shift `rx_s` into bit 7 of the shift register, shifting right, so the first bit received ends up at bit 0.
  - Reload the counter and increment the index. After the 8th bit → STOP.
- STOP, on sample, with `rx_s == 1`:
  - If the holding register is empty, or is being drained this same cycle (`rx_valid && rx_ready`), load `rx_data` and set `rx_valid`.
  - Otherwise pulse `overrun` and discard the new byte; `rx_data` is unchanged.
  - Next state IDLE.
- STOP, on sample, with `rx_s == 0`:
  - Pulse `framing_error` and discard the byte.
  - Next state WAIT_IDLE.
- WAIT_IDLE: stays until `rx_s == 1`, then → IDLE. This prevents a break (line held low) from re-triggering frames.
- `rx_valid` clears on transfer unless the same cycle loads a new byte.
- `rx_data` holds its value while `rx_valid` is high.
- Reset at any point, including mid-frame:
  - State → IDLE; the partial byte is discarded.
  - `rx_valid = 0`, `rx_data = 0`, `framing_error = 0`, `overrun = 0`, counter and index = 0.
  - Synchronizer = 1, so a line that is low at reset release starts a frame two cycles later.

## Timing
- Let t = the first cycle IDLE sees `rx_s == 0`. Pin fall is at t − 2 due to the synchronizer; N = `CLOCKS_PER_BIT`.
- Start bit sampled at t + N/2.
- Data bit i (0..7) sampled at t + N/2 + (i+1)·N.
- Stop bit sampled at t + N/2 + 9N.
- `rx_valid`, `framing_error` or `overrun` are visible at t + N/2 + 9N + 1.
- FSM is in IDLE at t + N/2 + 9N + 1, half a bit before the nominal end of the frame. Back-to-back frames are accepted with ±N/2 clock tolerance.
- Error pulses are exactly one cycle wide. `framing_error` and `overrun` are never asserted in the same cycle.
- Consumer handshake has zero-cycle acceptance; there is no combinational path from `rx_ready` to `rx_valid` except through the register.

## Structure
- Package `usart_pkg`:
  - `typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} usart_rx_state_t`.
  - `localparam USART_DATA_BITS = 8`.
  - Shared with `usart_tx` future rework.
- Sub-module `usart_sync`: 2-flop synchronizer with reset value parameter.
- FSM, counter, shift register and holding register live in `usart_rx`.

## Test plan
- N=16, send 0xA5 with `rx_ready=1`:
  - `rx_valid` pulses 1 cycle with `rx_data=0xA5`.
  - Pulse occurs 2+8+144+1 cycles after pin fall.
- Send 0x00 then 0xFF back-to-back, `rx_ready=0` until both are sent:
  - First byte 0x00 is held.
  - `overrun` pulses once at the second stop sample.
  - After `rx_ready`, `rx_data` still reads 0x00.
- Send a frame with stop bit 0, then hold the line low for 40 bits:
  - One `framing_error` pulse, no `rx_valid`.
  - No further activity until the line rises.
  - A subsequent 0x3C is received correctly.
- Drive a 5-clock low glitch on idle line:
  - Returns to IDLE; no outputs asserted.
  - A following 0x81 frame is received.
- Assert `reset` at data bit 4 of 0x55:
  - Outputs return to 0 next cycle.
  - The remaining bits produce no `rx_valid`; the next full frame 0xC3 is received.
- `rx_valid=1` and `rx_ready=1` on the stop-sample cycle of a new frame 0x12:
  - Old byte transfers, `rx_data=0x12`, `rx_valid` stays 1, no `overrun`.
